// File: rtl/run_detect_seq.sv
// run_detect_seq: bit-serial run-of-ones detector with a configurable run length.
// Each accepted byte is shifted LSB-first through a saturating run counter; the
// number of bit positions where the run reached the latched length is returned
// per word, and a saturating running total of those counts is kept.
module run_detect_seq #(
   parameter int DATA_W = 8,
   parameter int LEN_W  = 3,
   parameter int TOT_W  = 16,
   localparam int CNT_W = $clog2(DATA_W + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              det,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_hit,
   output logic [TOT_W-1:0]  total_count
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [DATA_W-1:0]   shreg;
   logic [DATA_W-1:0]   shreg_nx;
   logic [CNT_W-1:0]    bit_idx;
   logic [CNT_W-1:0]    bit_idx_nx;
   logic [CNT_W-1:0]    hit_cnt;
   logic [CNT_W-1:0]    hit_cnt_nx;
   logic [LEN_W-1:0]    run_cnt;
   logic [LEN_W-1:0]    run_cnt_nx;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    len_q_nx;
   logic [TOT_W-1:0]    total_nx;
   logic                det_nx;
   logic                out_hit_nx;
   logic                bit_b;
   logic [TOT_W:0]      sum;

   // Handshake flags decode straight from the state register.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == HOLD);
   assign out_count = hit_cnt;

   // Next-state and datapath update; clr overrides run tracking and the total.
   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      bit_idx_nx = bit_idx;
      hit_cnt_nx = hit_cnt;
      run_cnt_nx = run_cnt;
      len_q_nx   = len_q;
      total_nx   = total_count;
      bit_b      = 1'b0;
      sum        = {1'b0, total_count} + {{(TOT_W + 1 - CNT_W){1'b0}}, hit_cnt};
      case (state)
         IDLE: begin
            if (in_valid) begin
               shreg_nx   = in_data;
               len_q_nx   = (cfg_len == {LEN_W{1'b0}}) ? LEN_W'(1) : cfg_len;
               bit_idx_nx = {CNT_W{1'b0}};
               hit_cnt_nx = {CNT_W{1'b0}};
               // A run carried from the previous word must not exceed the new length.
               if (run_cnt > len_q_nx) begin
                  run_cnt_nx = len_q_nx;
               end else begin
                  run_cnt_nx = run_cnt;
               end
               state_nx   = SHIFT;
            end else begin
               state_nx   = IDLE;
            end
         end
         SHIFT: begin
            bit_b      = shreg[0];
            shreg_nx   = shreg >> 1;
            bit_idx_nx = bit_idx + CNT_W'(1);
            // Run counter saturates at the latched length, so it can never wrap.
            if (bit_b) begin
               run_cnt_nx = (run_cnt == len_q) ? len_q : (run_cnt + LEN_W'(1));
            end else begin
               run_cnt_nx = {LEN_W{1'b0}};
            end
            if (bit_b && (run_cnt_nx == len_q)) begin
               hit_cnt_nx = hit_cnt + CNT_W'(1);
            end else begin
               hit_cnt_nx = hit_cnt;
            end
            if (bit_idx == CNT_W'(DATA_W - 1)) begin
               state_nx = HOLD;
            end else begin
               state_nx = SHIFT;
            end
         end
         HOLD: begin
            if (out_ready) begin
               total_nx = sum[TOT_W] ? {TOT_W{1'b1}} : sum[TOT_W-1:0];
               state_nx = IDLE;
            end else begin
               state_nx = HOLD;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
      // clr: the bit consumed this edge still shifts out but is neither counted
      // nor allowed to start a run; hits already counted for the word survive.
      if (clr) begin
         run_cnt_nx = {LEN_W{1'b0}};
         total_nx   = {TOT_W{1'b0}};
         if (state == SHIFT) begin
            hit_cnt_nx = hit_cnt;
         end else begin
            hit_cnt_nx = hit_cnt_nx;
         end
      end else begin
         run_cnt_nx = run_cnt_nx;
      end
      det_nx     = (run_cnt_nx == len_q_nx) && (len_q_nx != {LEN_W{1'b0}});
      out_hit_nx = (hit_cnt_nx != {CNT_W{1'b0}});
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         shreg       <= {DATA_W{1'b0}};
         bit_idx     <= {CNT_W{1'b0}};
         hit_cnt     <= {CNT_W{1'b0}};
         run_cnt     <= {LEN_W{1'b0}};
         len_q       <= {LEN_W{1'b0}};
         total_count <= {TOT_W{1'b0}};
         det         <= 1'b0;
         out_hit     <= 1'b0;
      end else begin
         shreg       <= shreg_nx;
         bit_idx     <= bit_idx_nx;
         hit_cnt     <= hit_cnt_nx;
         run_cnt     <= run_cnt_nx;
         len_q       <= len_q_nx;
         total_count <= total_nx;
         det         <= det_nx;
         out_hit     <= out_hit_nx;
      end
   end

endmodule

// File: tb/tb_run_detect_seq.sv
// Testbench for run_detect_seq: directed plan scenarios plus randomized words
// checked against a bit-stream reference model of the run-length rules.
module tb_run_detect_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clr = 1'b0;
   logic [2:0]  cfg_len = 3'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = 8'd0;
   logic        det;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_count;
   logic        out_hit;
   logic [15:0] total_count;

   int checks = 0;
   int errors = 0;

   // reference model state
   int m_run = 0;
   int m_len = 0;
   int m_total = 0;

   run_detect_seq #(.DATA_W(8), .LEN_W(3), .TOT_W(16)) dut (
      .clk(clk), .rst(rst), .clr(clr), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .det(det), .out_valid(out_valid), .out_ready(out_ready),
      .out_count(out_count), .out_hit(out_hit), .total_count(total_count)
   );

   always #5 clk = ~clk;

   // Model one word: returns hit count and expected det after edges T..T+8.
   function automatic int model_word(input logic [7:0] d, input logic [2:0] cfg,
                                     input int clr_bit, output logic [8:0] edet);
      int cnt = 0;
      m_len = (cfg == 3'd0) ? 1 : int'(cfg);
      if (m_run > m_len) m_run = m_len;
      edet[0] = (m_run == m_len);
      for (int i = 0; i < 8; i++) begin
         if (i == clr_bit) begin
            m_run = 0;
            m_total = 0;
         end else if (d[i]) begin
            m_run = (m_run + 1 > m_len) ? m_len : m_run + 1;
            if (m_run == m_len) cnt++;
         end else begin
            m_run = 0;
         end
         edet[i+1] = (m_run == m_len);
      end
      return cnt;
   endfunction

   function automatic void model_hs(input int cnt, input bit clr_hs);
      if (clr_hs) begin
         m_total = 0;
         m_run = 0;
      end else begin
         m_total = (m_total + cnt > 65535) ? 65535 : m_total + cnt;
      end
   endfunction

   task automatic do_reset();
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_run = 0; m_len = 0; m_total = 0;
   endtask

   // Drive one full word transaction; entered and left at #1 after an edge.
   task automatic do_word(input logic [7:0] d, input logic [2:0] cfg, input int clr_bit,
                          input int hold, input bit keep_valid, input bit clr_hs,
                          output logic [8:0] det_tr, output logic [3:0] o_cnt,
                          output logic o_hit, output logic o_val, output bit stable,
                          output logic [15:0] o_tot, output logic o_val_after,
                          output bit acc_ok);
      logic [15:0] pre;
      in_data = d; cfg_len = cfg; in_valid = 1'b1; out_ready = 1'b0;
      acc_ok = 1'b0;
      for (int w = 0; w < 20 && !acc_ok; w++) begin
         if (in_ready === 1'b1) acc_ok = 1'b1;
         else begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 8'($urandom);
      det_tr[0] = det;
      for (int k = 1; k <= 8; k++) begin
         clr = (k - 1 == clr_bit);
         @(posedge clk); #1;
         clr = 1'b0;
         det_tr[k] = det;
      end
      o_val = out_valid; o_cnt = out_count; o_hit = out_hit; pre = total_count;
      stable = 1'b1;
      in_valid = keep_valid;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || out_count !== o_cnt || in_ready !== 1'b0 ||
             total_count !== pre) stable = 1'b0;
      end
      out_ready = 1'b1; clr = clr_hs;
      @(posedge clk); #1;
      out_ready = 1'b0; clr = 1'b0; in_valid = 1'b0;
      o_tot = total_count; o_val_after = out_valid;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_out_count got %0d want 0", out_count); end
      checks++; if (out_hit !== 1'b0) begin errors++; $display("FAIL reset_out_hit got %b want 0", out_hit); end
      checks++; if (det !== 1'b0) begin errors++; $display("FAIL reset_det got %b want 0", det); end
      checks++; if (total_count !== 16'd0) begin errors++; $display("FAIL reset_total got %0d want 0", total_count); end
   endtask

   task automatic test_directed();
      logic [7:0] td [5] = '{8'h0F, 8'hFF, 8'hC0, 8'h03, 8'hA5};
      logic [2:0] tl [5] = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd0};
      bit         tr [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      int         tc [5] = '{1, 5, 0, 1, 4};
      int         tt [5] = '{1, 5, 0, 1, 4};
      logic [8:0] det_tr, edet;
      logic [3:0] o_cnt; logic o_hit, o_val, o_va; bit st, acc; logic [15:0] o_tot;
      int ec;
      for (int i = 0; i < 5; i++) begin
         if (tr[i]) do_reset();
         ec = model_word(td[i], tl[i], -1, edet);
         do_word(td[i], tl[i], -1, 0, 1'b0, 1'b0, det_tr, o_cnt, o_hit, o_val, st, o_tot, o_va, acc);
         model_hs(ec, 1'b0);
         checks++; if (!acc) begin errors++; $display("FAIL dir_accept[%0d] got no in_ready want accept", i); end
         checks++; if (o_cnt !== 4'(tc[i])) begin errors++; $display("FAIL dir_count[%0d] got %0d want %0d", i, o_cnt, tc[i]); end
         checks++; if (o_hit !== (tc[i] != 0)) begin errors++; $display("FAIL dir_hit[%0d] got %b want %b", i, o_hit, tc[i] != 0); end
         checks++; if (o_val !== 1'b1) begin errors++; $display("FAIL dir_out_valid[%0d] got %b want 1", i, o_val); end
         checks++; if (det_tr !== edet) begin errors++; $display("FAIL dir_det_trace[%0d] got %b want %b", i, det_tr, edet); end
         checks++; if (o_tot !== 16'(tt[i])) begin errors++; $display("FAIL dir_total[%0d] got %0d want %0d", i, o_tot, tt[i]); end
         checks++; if (o_va !== 1'b0) begin errors++; $display("FAIL dir_valid_drop[%0d] got %b want 0", i, o_va); end
      end
   endtask

   task automatic test_hold_stall();
      logic [8:0] det_tr, edet;
      logic [3:0] o_cnt; logic o_hit, o_val, o_va; bit st, acc; logic [15:0] o_tot;
      int ec;
      do_reset();
      ec = model_word(8'h0F, 3'd4, -1, edet);
      do_word(8'h0F, 3'd4, -1, 5, 1'b1, 1'b0, det_tr, o_cnt, o_hit, o_val, st, o_tot, o_va, acc);
      model_hs(ec, 1'b0);
      checks++; if (st !== 1'b1) begin errors++; $display("FAIL stall_stable got %b want 1", st); end
      checks++; if (o_cnt !== 4'd1) begin errors++; $display("FAIL stall_count got %0d want 1", o_cnt); end
      checks++; if (o_tot !== 16'd1) begin errors++; $display("FAIL stall_total got %0d want 1", o_tot); end
      @(posedge clk); #1;
      checks++; if (total_count !== 16'd1) begin errors++; $display("FAIL stall_total_once got %0d want 1", total_count); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_idle got %b want 1", in_ready); end
   endtask

   task automatic test_rst_mid_shift();
      logic [8:0] det_tr, edet;
      logic [3:0] o_cnt; logic o_hit, o_val, o_va; bit st, acc; logic [15:0] o_tot;
      int ec;
      do_reset();
      ec = model_word(8'hFF, 3'd1, -1, edet);
      do_word(8'hFF, 3'd1, -1, 0, 1'b0, 1'b0, det_tr, o_cnt, o_hit, o_val, st, o_tot, o_va, acc);
      model_hs(ec, 1'b0);
      checks++; if (o_tot !== 16'd8) begin errors++; $display("FAIL rst_pre_total got %0d want 8", o_tot); end
      in_data = 8'hFF; cfg_len = 3'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (det !== 1'b1) begin errors++; $display("FAIL rst_pre_det got %b want 1", det); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; m_run = 0; m_len = 0; m_total = 0;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
      checks++; if (det !== 1'b0) begin errors++; $display("FAIL rst_det got %b want 0", det); end
      checks++; if (total_count !== 16'd0) begin errors++; $display("FAIL rst_total got %0d want 0", total_count); end
      repeat (10) begin @(posedge clk); #1; end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_discard got %b want 0", out_valid); end
   endtask

   task automatic test_clr();
      logic [8:0] det_tr, edet;
      logic [3:0] o_cnt; logic o_hit, o_val, o_va; bit st, acc; logic [15:0] o_tot;
      int ec;
      do_reset();
      ec = model_word(8'h7F, 3'd1, -1, edet);
      do_word(8'h7F, 3'd1, -1, 0, 1'b0, 1'b0, det_tr, o_cnt, o_hit, o_val, st, o_tot, o_va, acc);
      model_hs(ec, 1'b0);
      checks++; if (o_tot !== 16'd7) begin errors++; $display("FAIL clr_pre_total got %0d want 7", o_tot); end
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0; m_run = 0; m_total = 0;
      checks++; if (total_count !== 16'd0) begin errors++; $display("FAIL clr_idle_total got %0d want 0", total_count); end
      checks++; if (det !== 1'b0) begin errors++; $display("FAIL clr_idle_det got %b want 0", det); end
      ec = model_word(8'h01, 3'd2, -1, edet);
      do_word(8'h01, 3'd2, -1, 0, 1'b0, 1'b0, det_tr, o_cnt, o_hit, o_val, st, o_tot, o_va, acc);
      model_hs(ec, 1'b0);
      checks++; if (o_cnt !== 4'd0 || o_hit !== 1'b0) begin errors++; $display("FAIL clr_after_count got %0d/%b want 0/0", o_cnt, o_hit); end
      ec = model_word(8'hFF, 3'd2, 2, edet);
      do_word(8'hFF, 3'd2, 2, 0, 1'b0, 1'b0, det_tr, o_cnt, o_hit, o_val, st, o_tot, o_va, acc);
      model_hs(ec, 1'b0);
      checks++; if (o_cnt !== 4'd5) begin errors++; $display("FAIL clr_shift_count got %0d want 5", o_cnt); end
      checks++; if (det_tr !== edet) begin errors++; $display("FAIL clr_shift_det got %b want %b", det_tr, edet); end
      checks++; if (o_tot !== 16'd5) begin errors++; $display("FAIL clr_shift_total got %0d want 5", o_tot); end
      ec = model_word(8'h0F, 3'd1, -1, edet);
      do_word(8'h0F, 3'd1, -1, 2, 1'b0, 1'b1, det_tr, o_cnt, o_hit, o_val, st, o_tot, o_va, acc);
      model_hs(ec, 1'b1);
      checks++; if (o_cnt !== 4'd4) begin errors++; $display("FAIL clr_hs_count got %0d want 4", o_cnt); end
      checks++; if (o_tot !== 16'd0) begin errors++; $display("FAIL clr_hs_total got %0d want 0", o_tot); end
   endtask

   task automatic test_random();
      logic [8:0] det_tr, edet;
      logic [3:0] o_cnt; logic o_hit, o_val, o_va; bit st, acc; logic [15:0] o_tot;
      logic [7:0] d; logic [2:0] cfg; int cb, hold, ec; bit kv, ch;
      do_reset();
      for (int n = 0; n < 60; n++) begin
         d    = 8'($urandom);
         cfg  = 3'($urandom_range(0, 7));
         cb   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 7)) : -1;
         hold = int'($urandom_range(0, 3));
         kv   = 1'($urandom_range(0, 1));
         ch   = ($urandom_range(0, 9) == 0);
         ec = model_word(d, cfg, cb, edet);
         do_word(d, cfg, cb, hold, kv, ch, det_tr, o_cnt, o_hit, o_val, st, o_tot, o_va, acc);
         model_hs(ec, ch);
         checks++; if (!acc) begin errors++; $display("FAIL rnd_accept[%0d] got no in_ready want accept", n); end
         checks++; if (o_cnt !== 4'(ec)) begin errors++; $display("FAIL rnd_count[%0d] d=%h len=%0d got %0d want %0d", n, d, cfg, o_cnt, ec); end
         checks++; if (o_hit !== (ec != 0)) begin errors++; $display("FAIL rnd_hit[%0d] got %b want %b", n, o_hit, ec != 0); end
         checks++; if (o_val !== 1'b1) begin errors++; $display("FAIL rnd_out_valid[%0d] got %b want 1", n, o_val); end
         checks++; if (st !== 1'b1) begin errors++; $display("FAIL rnd_hold_stable[%0d] got %b want 1", n, st); end
         checks++; if (det_tr !== edet) begin errors++; $display("FAIL rnd_det[%0d] got %b want %b", n, det_tr, edet); end
         checks++; if (o_tot !== 16'(m_total)) begin errors++; $display("FAIL rnd_total[%0d] got %0d want %0d", n, o_tot, m_total); end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold_stall();
      test_rst_mid_shift();
      test_clr();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
